// File: rtl/mem_wr_packer_if.sv
// Byte-stream input, SRAM A-port write bus and frame status of the write packer.
// The slave modport is the packer; the master modport is whoever feeds it.
interface mem_wr_packer_if #(
  parameter int ADDR_WIDTH_W = 9,
  parameter int DATA_WIDTH_W = 16,
  parameter int DATA_WIDTH_R = 8
);
  logic [DATA_WIDTH_R-1:0] in_data;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic [DATA_WIDTH_W-1:0] wrdata_a;
  logic [ADDR_WIDTH_W-1:0] wraddr_a;
  logic                    wrena_n;
  logic                    frame_done;
  logic [ADDR_WIDTH_W:0]   frame_words;
  logic [ADDR_WIDTH_W-1:0] frame_base;
  logic                    overflow;
  logic                    clr_ovf;

  modport slave (
    input  in_data, in_valid, in_last, clr_ovf,
    output in_ready, wrdata_a, wraddr_a, wrena_n,
    output frame_done, frame_words, frame_base, overflow
  );

  modport master (
    output in_data, in_valid, in_last, clr_ovf,
    input  in_ready, wrdata_a, wraddr_a, wrena_n,
    input  frame_done, frame_words, frame_base, overflow
  );
endinterface

// File: rtl/mem_wr_packer.sv
// Write-side front end of the two-port SRAM: packs byte pairs (first byte high)
// into words, writes them at a circular address, pads odd frames and reports
// per-frame word count / base address plus a sticky capacity overflow flag.
module mem_wr_packer #(
  parameter int                    ADDR_WIDTH_W = 9,
  parameter int                    DATA_WIDTH_W = 16,
  parameter int                    DATA_WIDTH_R = 8,
  parameter int                    DATA_DEPTH_W = 512,
  parameter logic [DATA_WIDTH_R-1:0] PAD_BYTE   = 8'h00
) (
  input  logic             clk_a,
  input  logic             rst,
  mem_wr_packer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH_W-1:0] PTR_MAX   = ADDR_WIDTH_W'(DATA_DEPTH_W - 1);
  localparam logic [ADDR_WIDTH_W:0]   WORDS_MAX = (ADDR_WIDTH_W + 1)'(DATA_DEPTH_W);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH_R-1:0] hi_q, hi_d;
  logic [ADDR_WIDTH_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH_W-1:0] wrdata_q, wrdata_d;
  logic [ADDR_WIDTH_W-1:0] wraddr_q, wraddr_d;
  logic                    wrena_q, wrena_d;
  logic                    frame_done_q, frame_done_d;
  logic [ADDR_WIDTH_W:0]   frame_words_q, frame_words_d;
  logic [ADDR_WIDTH_W-1:0] frame_base_q, frame_base_d;
  logic                    overflow_q, overflow_d;

  logic                    accept_s;
  logic                    write_s;
  logic                    ovf_set_s;
  logic [DATA_WIDTH_W-1:0] word_s;

  // The frame-close cycle and reset are the only times a byte is refused.
  assign bus.in_ready = (state_q != ST_DONE) && !rst;
  assign accept_s     = bus.in_valid && bus.in_ready;

  assign bus.wrdata_a    = wrdata_q;
  assign bus.wraddr_a    = wraddr_q;
  assign bus.wrena_n     = wrena_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_words = frame_words_q;
  assign bus.frame_base  = frame_base_q;
  assign bus.overflow    = overflow_q;

  // Next-state: byte pairing FSM, write bus, frame bookkeeping and overflow.
  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    wr_ptr_d      = wr_ptr_q;
    wrdata_d      = wrdata_q;
    wraddr_d      = wraddr_q;
    wrena_d       = 1'b0;
    frame_done_d  = 1'b0;
    frame_words_d = frame_words_q;
    frame_base_d  = frame_base_q;
    write_s       = 1'b0;
    word_s        = {hi_q, bus.in_data};

    case (state_q)
      ST_EMPTY: begin
        if (accept_s && bus.in_last) begin
          write_s = 1'b1;
          word_s  = {bus.in_data, PAD_BYTE};
          state_d = ST_DONE;
        end else if (accept_s) begin
          hi_d    = bus.in_data;
          state_d = ST_HALF;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_HALF: begin
        if (accept_s) begin
          write_s = 1'b1;
          word_s  = {hi_q, bus.in_data};
          state_d = bus.in_last ? ST_DONE : ST_EMPTY;
        end else begin
          state_d = ST_HALF;
        end
      end
      ST_DONE: begin
        // Counter is cleared as the close cycle ends, so it is still valid
        // alongside frame_done.
        state_d       = ST_EMPTY;
        frame_words_d = {(ADDR_WIDTH_W + 1){1'b0}};
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    ovf_set_s = write_s && (frame_words_q == WORDS_MAX);

    if (write_s) begin
      wrdata_d     = word_s;
      wraddr_d     = wr_ptr_q;
      wrena_d      = 1'b1;
      frame_done_d = (state_d == ST_DONE);
      wr_ptr_d     = (wr_ptr_q == PTR_MAX) ? {ADDR_WIDTH_W{1'b0}}
                                           : wr_ptr_q + ADDR_WIDTH_W'(1);
      if (frame_words_q == {(ADDR_WIDTH_W + 1){1'b0}}) begin
        frame_base_d = wr_ptr_q;
      end else begin
        frame_base_d = frame_base_q;
      end
      if (ovf_set_s) begin
        frame_words_d = frame_words_q;
      end else begin
        frame_words_d = frame_words_q + (ADDR_WIDTH_W + 1)'(1);
      end
    end else begin
      wrena_d = 1'b0;
    end

    // A new overflow wins over a simultaneous clear request.
    if (ovf_set_s) begin
      overflow_d = 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State and registered outputs; reset discards any half-held byte.
  always_ff @(posedge clk_a or posedge rst) begin
    if (rst) begin
      state_q       <= ST_EMPTY;
      hi_q          <= {DATA_WIDTH_R{1'b0}};
      wr_ptr_q      <= {ADDR_WIDTH_W{1'b0}};
      wrdata_q      <= {DATA_WIDTH_W{1'b0}};
      wraddr_q      <= {ADDR_WIDTH_W{1'b0}};
      wrena_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_words_q <= {(ADDR_WIDTH_W + 1){1'b0}};
      frame_base_q  <= {ADDR_WIDTH_W{1'b0}};
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      wr_ptr_q      <= wr_ptr_d;
      wrdata_q      <= wrdata_d;
      wraddr_q      <= wraddr_d;
      wrena_q       <= wrena_d;
      frame_done_q  <= frame_done_d;
      frame_words_q <= frame_words_d;
      frame_base_q  <= frame_base_d;
      overflow_q    <= overflow_d;
    end
  end

endmodule

// File: tb/tb_mem_wr_packer.sv
// Scoreboard bench for mem_wr_packer: stimulus pushes expected writes and
// frame reports; a negedge monitor pops and compares whenever the DUT
// presents a write strobe or a frame_done pulse.
module tb_mem_wr_packer;

  logic clk_a = 1'b0;
  logic rst   = 1'b1;

  mem_wr_packer_if #(.ADDR_WIDTH_W(9), .DATA_WIDTH_W(16), .DATA_WIDTH_R(8)) bus ();

  mem_wr_packer #(
    .ADDR_WIDTH_W(9), .DATA_WIDTH_W(16), .DATA_WIDTH_R(8),
    .DATA_DEPTH_W(512), .PAD_BYTE(8'h00)
  ) dut (
    .clk_a (clk_a),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk_a = ~clk_a;

  int cyc = 0;
  always @(posedge clk_a) cyc <= cyc + 1;

  typedef struct {
    logic [8:0]  addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [9:0] words;
    logic [8:0] base;
    logic       ovf;
    int         cyc;
  } fr_t;

  wr_t wq[$];
  fr_t fq[$];

  int checks = 0;
  int errors = 0;
  int acc_cyc = 0;
  int waited = 0;
  logic [8:0] eptr = 9'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Offer one byte until accepted; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] d, input logic last);
    int g = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    while (!bus.in_ready && g < 20) begin
      @(negedge clk_a);
      g++;
    end
    waited = g;
    if (g >= 20) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=in_ready_low required=accept_within_20");
    end
    @(negedge clk_a);
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic exp_wr(input logic [8:0] a, input logic [15:0] d);
    wq.push_back('{a, d, acc_cyc});
  endtask

  task automatic exp_fr(input logic [9:0] w, input logic [8:0] b, input logic o);
    fq.push_back('{w, b, o, acc_cyc});
  endtask

  // Frame of n bytes with a simple byte pattern; expectations derived from the pattern.
  task automatic gen_frame(input int n, input int seed, input logic ovf_exp, input logic clr_on_last);
    logic [8:0] base;
    logic [7:0] hi;
    logic [7:0] b;
    logic       last;
    int         nw;
    base = eptr;
    hi   = 8'h00;
    nw   = 0;
    for (int i = 0; i < n; i++) begin
      b    = 8'(seed + i * 7);
      last = (i == n - 1);
      bus.clr_ovf = last && clr_on_last;
      send(b, last);
      bus.clr_ovf = 1'b0;
      if ((i % 2) == 0 && !last) begin
        hi = b;
      end else begin
        exp_wr(eptr, ((i % 2) == 0) ? {b, 8'h00} : {hi, b});
        eptr = eptr + 9'd1;
        nw++;
      end
    end
    exp_fr((nw > 512) ? 10'd512 : 10'(nw), base, ovf_exp);
  endtask

  // Monitor: every write strobe and frame_done pulse must match the head of its queue.
  always @(negedge clk_a) begin
    #1;
    if (!rst) begin
      if (bus.wrena_n) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL spurious_write actual=%0h@%0h required=no_write", bus.wrdata_a, bus.wraddr_a);
        end else begin
          wr_t e;
          e = wq.pop_front();
          if (bus.wraddr_a !== e.addr || bus.wrdata_a !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL write actual=%0h@%0h cyc%0d required=%0h@%0h cyc%0d",
                     bus.wrdata_a, bus.wraddr_a, cyc, e.data, e.addr, e.cyc);
          end
        end
      end
      if (bus.frame_done) begin
        checks++;
        if (fq.size() == 0) begin
          errors++;
          $display("FAIL spurious_frame_done actual=words%0d base%0h required=none",
                   bus.frame_words, bus.frame_base);
        end else begin
          fr_t f;
          f = fq.pop_front();
          if (bus.frame_words !== f.words || bus.frame_base !== f.base ||
              bus.overflow !== f.ovf || bus.in_ready !== 1'b0 || cyc != f.cyc) begin
            errors++;
            $display("FAIL frame actual=words%0d base%0h ovf%0b rdy%0b cyc%0d required=words%0d base%0h ovf%0b rdy0 cyc%0d",
                     bus.frame_words, bus.frame_base, bus.overflow, bus.in_ready, cyc,
                     f.words, f.base, f.ovf, f.cyc);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.clr_ovf  = 1'b0;
    rst          = 1'b1;
    repeat (3) @(negedge clk_a);

    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_wrena", bus.wrena_n, 0);
    chk("rst_wraddr", bus.wraddr_a, 0);
    chk("rst_wrdata", bus.wrdata_a, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_frame_words", bus.frame_words, 0);
    chk("rst_frame_base", bus.frame_base, 0);
    chk("rst_overflow", bus.overflow, 0);
    rst = 1'b0;
    @(negedge clk_a);
    chk("ready_after_rst", bus.in_ready, 1);

    // Even frame, back to back.
    send(8'h11, 1'b0);
    send(8'h22, 1'b0); exp_wr(9'd0, 16'h1122);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1); exp_wr(9'd1, 16'h3344); exp_fr(10'd2, 9'd0, 1'b0);

    // Odd frame right after: exactly one refused cycle at the boundary.
    send(8'hAA, 1'b0); chk("boundary_idle_cycles", waited, 1);
    send(8'hBB, 1'b0); exp_wr(9'd2, 16'hAABB);
    send(8'hCC, 1'b1); exp_wr(9'd3, 16'hCC00); exp_fr(10'd2, 9'd2, 1'b0);

    // Valid gaps inside a frame.
    send(8'h55, 1'b0);
    repeat (3) @(negedge clk_a);
    send(8'h66, 1'b1); exp_wr(9'd4, 16'h5566); exp_fr(10'd1, 9'd4, 1'b0);
    eptr = 9'd5;

    // 1030 bytes across frames: address wraps 511 -> 0.
    for (int f = 0; f < 103; f++) gen_frame(10, f * 13, 1'b0, 1'b0);
    chk("overflow_still_clear", bus.overflow, 0);

    // Oversize frame: 513 writes, overflow set on the last one.
    gen_frame(1026, 3, 1'b1, 1'b0);
    @(negedge clk_a);
    chk("overflow_sticky", bus.overflow, 1);
    bus.clr_ovf = 1'b1;
    @(negedge clk_a);
    bus.clr_ovf = 1'b0;
    chk("overflow_cleared", bus.overflow, 0);

    // Second oversize frame with clr_ovf coincident with the overflowing write.
    gen_frame(1026, 5, 1'b1, 1'b1);
    @(negedge clk_a);
    chk("overflow_set_beats_clear", bus.overflow, 1);

    // Reset while a half word is held.
    send(8'h77, 1'b0);
    #2 rst = 1'b1;
    @(negedge clk_a);
    chk("rst_half_wraddr", bus.wraddr_a, 0);
    chk("rst_half_wrena", bus.wrena_n, 0);
    chk("rst_half_overflow", bus.overflow, 0);
    chk("rst_half_in_ready", bus.in_ready, 0);
    rst  = 1'b0;
    eptr = 9'd0;
    @(negedge clk_a);
    send(8'h01, 1'b0);
    send(8'h02, 1'b1); exp_wr(9'd0, 16'h0102); exp_fr(10'd1, 9'd0, 1'b0);

    repeat (4) @(negedge clk_a);
    chk("write_queue_drained", wq.size(), 0);
    chk("frame_queue_drained", fq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
